ekf_stage_host: RTL and testbench

- Initiator side of the EKF accelerator stage handshake; takes the place of the PS-side driver.
- Accepts queued commands (predict, new landmark, update, map clear) through a small FIFO.
- Drives the one-hot stage_val, the operands (vlr/alpha or rk/phi), l_k and landmark_num.
- Waits for the matching stage_rdy pulse, with a timeout, and reports a completion record per command.

---
 rtl/ekf_host_pkg.sv | 39 +++
 rtl/ekf_cmd_fifo.sv | 55 +++++
 rtl/ekf_stage_host.sv | 174 +++++++++++++++++
 tb/tb_ekf_stage_host.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ekf_host_pkg.sv
// Shared encodings for the EKF stage host: command ops, stage bits, FSM states.
package ekf_host_pkg;

    // Command opcodes as carried on cmd_op / done_op.
    typedef enum logic [1:0] {
        OP_PREDICT = 2'd0,
        OP_NEWLM   = 2'd1,
        OP_UPDATE  = 2'd2,
        OP_CLEAR   = 2'd3
    } op_e;

    // Bit positions inside the one-hot stage_val / stage_rdy vectors.
    localparam int STG_PREDICT = 0;
    localparam int STG_NEWLM   = 1;
    localparam int STG_UPDATE  = 2;
    localparam int STG_W       = 3;

    // Host sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

    // One-hot stage request for an op; map clear never issues a stage.
    function automatic logic [STG_W-1:0] stage_onehot(input op_e op);
        logic [STG_W-1:0] v;
        v = '0;
        case (op)
            OP_PREDICT: v[STG_PREDICT] = 1'b1;
            OP_NEWLM:   v[STG_NEWLM]   = 1'b1;
            OP_UPDATE:  v[STG_UPDATE]  = 1'b1;
            default:    v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/ekf_cmd_fifo.sv
// Command FIFO: pointer-based ring buffer whose read port is registered on pop.
module ekf_cmd_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wr_data,
    input  logic         pop,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    // Extra pointer bit tells full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage write; reading the same slot on a full push+pop returns the old entry.
    // NOTE: the storage array is deliberately not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Pointer update and registered read port.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_data <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_data <= mem[rd_ptr[AW-1:0]];
                rd_ptr  <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ekf_stage_host.sv
// EKF stage host: queues commands, validates them, issues one-hot stages and reports completion.
module ekf_stage_host
    import ekf_host_pkg::*;
#(
    parameter int DW         = 32,
    parameter int LM_W       = 10,
    parameter int MAX_LM     = 1023,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 4096
) (
    input  logic                 clk,
    input  logic                 sys_rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [DW-1:0]        cmd_arg0,
    input  logic [DW-1:0]        cmd_arg1,
    input  logic [LM_W-1:0]      cmd_lk,
    output logic [STG_W-1:0]     stage_val,
    input  logic [STG_W-1:0]     stage_rdy,
    output logic [LM_W-1:0]      landmark_num,
    output logic [LM_W-1:0]      l_k,
    output logic signed [DW-1:0] vlr,
    output logic signed [DW-1:0] alpha,
    output logic signed [DW-1:0] rk,
    output logic signed [DW-1:0] phi,
    output logic                 done_valid,
    output logic [1:0]           done_op,
    output logic                 done_err,
    output logic                 busy
);
    localparam int FW = 2 + 2 * DW + LM_W;
    localparam int TW = $clog2(TIMEOUT);

    state_e            state_q, state_d;
    logic [FW-1:0]     fifo_rd;
    logic              fifo_full, fifo_empty, push, pop;
    op_e               q_op;
    logic [DW-1:0]     q_arg0, q_arg1;
    logic [LM_W-1:0]   q_lk;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [STG_W-1:0]  stage_val_d;
    logic [LM_W-1:0]   lm_d, lk_d;
    logic [DW-1:0]     vlr_d, alpha_d, rk_d, phi_d;
    logic              done_valid_d, done_err_d;
    logic [1:0]        done_op_d;

    // A full FIFO still accepts a push in the cycle the sequencer pops it.
    assign pop       = (state_q == ST_IDLE) && !fifo_empty;
    assign cmd_ready = sys_rst_n && (!fifo_full || pop);
    assign push      = cmd_valid && cmd_ready;
    assign busy      = (state_q != ST_IDLE) || !fifo_empty;

    ekf_cmd_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (sys_rst_n),
        .push    (push),
        .wr_data ({cmd_op, cmd_arg0, cmd_arg1, cmd_lk}),
        .pop     (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // The FIFO read register is the current command; it holds until the next pop.
    assign q_op   = op_e'(fifo_rd[FW-1 -: 2]);
    assign q_arg0 = fifo_rd[FW-3 -: DW];
    assign q_arg1 = fifo_rd[LM_W +: DW];
    assign q_lk   = fifo_rd[LM_W-1:0];

    // Next-state, operand loading, completion reporting and timeout counting.
    // NOTE: every target gets a default first, so no path through the case can infer a latch.
    always_comb begin
        state_d      = state_q;
        tmo_d        = tmo_q;
        stage_val_d  = stage_val;
        lm_d         = landmark_num;
        lk_d         = l_k;
        vlr_d        = vlr;
        alpha_d      = alpha;
        rk_d         = rk;
        phi_d        = phi;
        done_valid_d = 1'b0;
        done_op_d    = '0;
        done_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                state_d   = ST_IDLE;
                done_op_d = q_op;
                if (q_op == OP_CLEAR) begin
                    lm_d         = '0;
                    done_valid_d = 1'b1;
                end else if ((q_op == OP_NEWLM && landmark_num == LM_W'(MAX_LM)) ||
                             (q_op == OP_UPDATE && q_lk >= landmark_num)) begin
                    done_valid_d = 1'b1;
                    done_err_d   = 1'b1;
                end else begin
                    done_op_d = '0;
                    if (q_op == OP_PREDICT) begin
                        vlr_d   = q_arg0;
                        alpha_d = q_arg1;
                    end else begin
                        rk_d  = q_arg0;
                        phi_d = q_arg1;
                        lk_d  = (q_op == OP_NEWLM) ? landmark_num : q_lk;
                    end
                    stage_val_d = stage_onehot(q_op);
                    tmo_d       = '0;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (|(stage_rdy & stage_val)) begin
                    stage_val_d  = '0;
                    done_valid_d = 1'b1;
                    done_op_d    = q_op;
                    if (stage_val[STG_NEWLM]) lm_d = landmark_num + LM_W'(1);
                    state_d = ST_GAP;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    stage_val_d  = '0;
                    done_valid_d = 1'b1;
                    done_op_d    = q_op;
                    done_err_d   = 1'b1;
                    state_d      = ST_GAP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    // Registered stage outputs, operands, map count and completion record.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tmo_q        <= '0;
            stage_val    <= '0;
            landmark_num <= '0;
            l_k          <= '0;
            vlr          <= '0;
            alpha        <= '0;
            rk           <= '0;
            phi          <= '0;
            done_valid   <= 1'b0;
            done_op      <= '0;
            done_err     <= 1'b0;
        end else begin
            tmo_q        <= tmo_d;
            stage_val    <= stage_val_d;
            landmark_num <= lm_d;
            l_k          <= lk_d;
            vlr          <= vlr_d;
            alpha        <= alpha_d;
            rk           <= rk_d;
            phi          <= phi_d;
            done_valid   <= done_valid_d;
            done_op      <= done_op_d;
            done_err     <= done_err_d;
        end
    end

endmodule

// File: tb/tb_ekf_stage_host.sv
// Self-checking bench for ekf_stage_host against a queue-based command model.
module tb_ekf_stage_host;

    localparam int DW = 32;
    localparam int LM_W = 10;
    localparam int MAX_LM = 1023;
    localparam int FIFO_DEPTH = 4;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic sys_rst_n = 1'b0;
    logic cmd_valid = 1'b0;
    logic cmd_ready;
    logic [1:0] cmd_op = '0;
    logic [DW-1:0] cmd_arg0 = '0, cmd_arg1 = '0;
    logic [LM_W-1:0] cmd_lk = '0;
    logic [2:0] stage_val;
    logic [2:0] stage_rdy = '0;
    logic [LM_W-1:0] landmark_num, l_k;
    logic signed [DW-1:0] vlr, alpha, rk, phi;
    logic done_valid, done_err, busy;
    logic [1:0] done_op;

    ekf_stage_host #(.DW(DW), .LM_W(LM_W), .MAX_LM(MAX_LM), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .sys_rst_n(sys_rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg0(cmd_arg0), .cmd_arg1(cmd_arg1), .cmd_lk(cmd_lk),
        .stage_val(stage_val), .stage_rdy(stage_rdy), .landmark_num(landmark_num), .l_k(l_k),
        .vlr(vlr), .alpha(alpha), .rk(rk), .phi(phi),
        .done_valid(done_valid), .done_op(done_op), .done_err(done_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]      op;
        logic [DW-1:0]   a0;
        logic [DW-1:0]   a1;
        logic [LM_W-1:0] lk;
    } cmd_t;

    cmd_t exp_q[$];
    int m_lm = 0;
    logic [DW-1:0] m_vlr = '0, m_alpha = '0, m_rk = '0, m_phi = '0;
    logic [LM_W-1:0] m_lk = '0;
    int tests = 0;
    int fails = 0;

    // Offer one command as soon as the host is ready, and record it in the model queue.
    task automatic push_cmd(input logic [1:0] op, input logic [DW-1:0] a0, input logic [DW-1:0] a1,
                            input logic [LM_W-1:0] lk);
        cmd_t c;
        int t = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        tests++;
        if (cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL push_ready: cmd_ready=%0b required 1", cmd_ready);
            return;
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_arg0 = a0; cmd_arg1 = a1; cmd_lk = lk;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        c.op = op; c.a0 = a0; c.a1 = a1; c.lk = lk;
        exp_q.push_back(c);
    endtask

    // Complete the oldest queued command. mode 0: ack after delay, 1: never ack, 2: wrong bits first.
    task automatic serve(input int mode, input int delay, input bit check_len);
        cmd_t c;
        logic [2:0] exp_stg;
        bit refuse, acked, hold_ok;
        int t, hi, exp_hi;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL serve_queue: model queue empty");
            return;
        end
        c = exp_q.pop_front();
        refuse = (c.op == 2'd1 && m_lm == MAX_LM) || (c.op == 2'd2 && int'(c.lk) >= m_lm);
        exp_stg = (c.op == 2'd0) ? 3'b001 : (c.op == 2'd1) ? 3'b010 : (c.op == 2'd2) ? 3'b100 : 3'b000;
        t = 0;
        while (stage_val === 3'b000 && done_valid !== 1'b1 && t < 64) begin
            @(negedge clk);
            t++;
        end
        if (t >= 64) begin
            fails++;
            $display("FAIL serve_wait op=%0d: no stage or done within 64 cycles", c.op);
            return;
        end
        if (c.op == 2'd3 || refuse) begin
            if (stage_val !== 3'b000 || done_valid !== 1'b1 || done_op !== c.op || done_err !== refuse) begin
                fails++;
                $display("FAIL no_stage op=%0d: stage_val=%b done=%b op=%0d err=%b required 000/1/%0d/%b",
                         c.op, stage_val, done_valid, done_op, done_err, c.op, refuse);
            end
            if (c.op == 2'd3) m_lm = 0;
        end else begin
            if (c.op == 2'd0) begin
                m_vlr = c.a0; m_alpha = c.a1;
            end else begin
                m_rk = c.a0; m_phi = c.a1;
                m_lk = (c.op == 2'd1) ? LM_W'(m_lm) : c.lk;
            end
            if (stage_val !== exp_stg) begin
                fails++;
                $display("FAIL stage_val op=%0d: got %b required %b", c.op, stage_val, exp_stg);
            end
            tests++;
            if ({vlr, alpha, rk, phi} !== {m_vlr, m_alpha, m_rk, m_phi}) begin
                fails++;
                $display("FAIL operands: got %h %h %h %h required %h %h %h %h",
                         vlr, alpha, rk, phi, m_vlr, m_alpha, m_rk, m_phi);
            end
            tests++;
            if (l_k !== m_lk || landmark_num !== LM_W'(m_lm)) begin
                fails++;
                $display("FAIL index: l_k=%0d lm=%0d required %0d %0d", l_k, landmark_num, m_lk, m_lm);
            end
            acked = (mode != 1) && (delay <= TIMEOUT - 1);
            exp_hi = acked ? delay + 1 : TIMEOUT;
            hi = 0;
            hold_ok = 1'b1;
            while (hi < TIMEOUT + 4) begin
                if (stage_val !== exp_stg || {vlr, alpha, rk, phi} !== {m_vlr, m_alpha, m_rk, m_phi} ||
                    l_k !== m_lk || landmark_num !== LM_W'(m_lm) || done_valid !== 1'b0)
                    hold_ok = 1'b0;
                if (mode != 1 && hi == delay) stage_rdy = exp_stg;
                else if (mode == 2 && hi == 0) stage_rdy = ~exp_stg;
                else stage_rdy = 3'b000;
                hi++;
                @(posedge clk);
                #1 stage_rdy = 3'b000;
                @(negedge clk);
                if (stage_val === 3'b000) break;
            end
            if (acked && c.op == 2'd1) m_lm++;
            tests++;
            if (!hold_ok) begin
                fails++;
                $display("FAIL hold op=%0d: stage_val/operands changed while waiting", c.op);
            end
            if (check_len) begin
                tests++;
                if (hi !== exp_hi) begin
                    fails++;
                    $display("FAIL stage_len op=%0d: high %0d cycles required %0d", c.op, hi, exp_hi);
                end
            end
            tests++;
            if (stage_val !== 3'b000 || done_valid !== 1'b1 || done_op !== c.op || done_err !== !acked ||
                landmark_num !== LM_W'(m_lm)) begin
                fails++;
                $display("FAIL stage_done op=%0d: sv=%b done=%b op=%0d err=%b lm=%0d required 000/1/%0d/%b/%0d",
                         c.op, stage_val, done_valid, done_op, done_err, landmark_num, c.op, !acked, m_lm);
            end
        end
        @(negedge clk);
        tests++;
        if (done_valid !== 1'b0 || done_op !== 2'd0 || done_err !== 1'b0 || stage_val !== 3'b000) begin
            fails++;
            $display("FAIL done_pulse: done=%b op=%0d err=%b sv=%b required 0/0/0/000",
                     done_valid, done_op, done_err, stage_val);
        end
    endtask

    task automatic test_reset();
        #12;
        tests++;
        if ({stage_val, vlr, alpha, rk, phi, l_k, landmark_num, done_valid, done_op, done_err, busy, cmd_ready} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: some output nonzero sv=%b lm=%0d ready=%b busy=%b",
                     stage_val, landmark_num, cmd_ready, busy);
        end
        @(negedge clk);
        #2 sys_rst_n = 1'b1;
        #1;
        tests++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: ready=%b busy=%b required 1 0", cmd_ready, busy);
        end
    endtask

    task automatic test_predict();
        push_cmd(2'd0, 32'h0001_0000, 32'h0000_8000, '0);
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (stage_val !== 3'b000) begin
            fails++;
            $display("FAIL latency_early: stage_val=%b required 000 before edge N+2", stage_val);
        end
        @(negedge clk);
        tests++;
        if (stage_val !== 3'b001) begin
            fails++;
            $display("FAIL latency: stage_val=%b required 001 after edge N+2", stage_val);
        end
        serve(0, 5, 1'b1);
    endtask

    task automatic test_newlm_refuse();
        for (int i = 0; i < 3; i++) begin
            push_cmd(2'd1, $urandom, $urandom, '0);
            serve(0, $urandom_range(0, 3), 1'b1);
        end
        tests++;
        if (landmark_num !== 10'd3) begin
            fails++;
            $display("FAIL newlm_count: landmark_num=%0d required 3", landmark_num);
        end
        push_cmd(2'd2, $urandom, $urandom, 10'd5);
        serve(0, 0, 1'b1);
    endtask

    task automatic test_timeout();
        push_cmd(2'd3, '0, '0, '0);
        serve(0, 0, 1'b1);
        push_cmd(2'd1, $urandom, $urandom, '0);
        serve(0, 1, 1'b1);
        push_cmd(2'd2, $urandom, $urandom, 10'd0);
        serve(1, 0, 1'b1);
        tests++;
        if (landmark_num !== 10'd1) begin
            fails++;
            $display("FAIL timeout_count: landmark_num=%0d required 1", landmark_num);
        end
    endtask

    task automatic test_wrong_bit();
        push_cmd(2'd1, $urandom, $urandom, '0);
        serve(2, 3, 1'b1);
        push_cmd(2'd0, $urandom, $urandom, '0);
        serve(0, TIMEOUT - 1, 1'b1);
    endtask

    task automatic test_backpressure();
        logic [1:0] ops [5];
        ops[0] = 2'd0; ops[1] = 2'd1; ops[2] = 2'd2; ops[3] = 2'd1; ops[4] = 2'd0;
        for (int i = 0; i < 5; i++) push_cmd(ops[i], $urandom, $urandom, 10'd0);
        @(negedge clk);
        tests++;
        if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL backpressure: ready=%b busy=%b required 0 1", cmd_ready, busy);
        end
        serve(0, 0, 1'b0);
        for (int i = 1; i < 5; i++) serve(0, $urandom_range(0, 3), 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [1:0] op;
            int mode, dly;
            op = 2'($urandom_range(0, 9) < 1 ? 3 : $urandom_range(0, 2));
            mode = ($urandom_range(0, 7) == 0) ? 1 : ($urandom_range(0, 3) == 0 ? 2 : 0);
            dly = $urandom_range(1, 6);
            push_cmd(op, $urandom, $urandom, LM_W'($urandom_range(0, m_lm + 1)));
            serve(mode, dly, 1'b1);
        end
    endtask

    task automatic test_reset_mid_wait();
        int t = 0;
        push_cmd(2'd1, $urandom, $urandom, '0);
        serve(0, 0, 1'b1);
        push_cmd(2'd2, $urandom, $urandom, 10'd0);
        push_cmd(2'd0, $urandom, $urandom, '0);
        push_cmd(2'd1, $urandom, $urandom, '0);
        while (stage_val !== 3'b100 && t < 32) begin
            @(negedge clk);
            t++;
        end
        tests++;
        if (stage_val !== 3'b100) begin
            fails++;
            $display("FAIL mid_wait_setup: stage_val=%b required 100", stage_val);
        end
        #2 sys_rst_n = 1'b0;
        #1;
        tests++;
        if ({stage_val, vlr, alpha, rk, phi, l_k, landmark_num, done_valid, done_op, done_err, busy, cmd_ready} !== '0) begin
            fails++;
            $display("FAIL async_reset: sv=%b lm=%0d busy=%b ready=%b required all 0",
                     stage_val, landmark_num, busy, cmd_ready);
        end
        exp_q.delete();
        m_lm = 0; m_vlr = '0; m_alpha = '0; m_rk = '0; m_phi = '0; m_lk = '0;
        @(negedge clk);
        @(negedge clk);
        #2 sys_rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tests++;
            if (done_valid !== 1'b0 || stage_val !== 3'b000 || busy !== 1'b0 || landmark_num !== 10'd0) begin
                fails++;
                $display("FAIL post_reset: done=%b sv=%b busy=%b lm=%0d required 0 000 0 0",
                         done_valid, stage_val, busy, landmark_num);
            end
        end
    endtask

    task automatic test_max_lm();
        while (m_lm < MAX_LM) begin
            push_cmd(2'd1, $urandom, $urandom, '0);
            serve(0, 0, 1'b0);
        end
        tests++;
        if (landmark_num !== 10'(MAX_LM)) begin
            fails++;
            $display("FAIL max_count: landmark_num=%0d required %0d", landmark_num, MAX_LM);
        end
        push_cmd(2'd1, $urandom, $urandom, '0);
        serve(0, 0, 1'b1);
        push_cmd(2'd2, $urandom, $urandom, 10'(MAX_LM - 1));
        serve(0, 2, 1'b1);
        push_cmd(2'd3, '0, '0, '0);
        serve(0, 0, 1'b1);
        push_cmd(2'd1, $urandom, $urandom, '0);
        serve(0, 1, 1'b1);
    endtask

    initial begin
        test_reset();
        test_predict();
        test_newlm_refuse();
        test_timeout();
        test_wrong_bit();
        test_backpressure();
        test_random();
        test_reset_mid_wait();
        test_max_lm();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
